cg_memory_arbiter: RTL and testbench
====================================

// Module: cg_memory_arbiter
// PURPOSE
//  Shares one cg_memory_beh-style memory port among N_REQ requesters.
//  Write and read-address channels are arbitrated independently, each round-robin.
//  Read responses return to the issuing requester via an in-order owner-ID FIFO.
//  Sits between bus masters (core fetch/LSU/DMA) and the memory model or SRAM wrapper.
// PARAMETERS
//  N_REQ          4   number of requesters (>=2)
//  DATA_WIDTH     32  data bits per word
//  ADDR_WIDTH     32  address bits
//  MAX_OUTSTANDING 4  owner-FIFO depth = max reads in flight (power of 2)
// PORTS
//  i_clk       in   1                 clock; all state updates on rising edge
//  i_rstn      in   1                 reset, synchronous, active-low
//  i_w_valid   in   N_REQ             per-requester write request
//  i_w_addr    in   N_REQ*ADDR_WIDTH  packed write addresses, req i at [i*AW +: AW]
//  i_w_data    in   N_REQ*DATA_WIDTH  packed write data
//  o_w_ready   out  N_REQ             write accepted (one-hot or zero)
//  i_ra_valid  in   N_REQ             per-requester read-address request
//  i_ra_addr   in   N_REQ*ADDR_WIDTH  packed read addresses
//  o_ra_ready  out  N_REQ             read address accepted (one-hot or zero)
//  o_r_valid   out  N_REQ             read data valid, routed to owner
//  o_r_data    out  DATA_WIDTH        read data, broadcast to all requesters
//  i_r_ready   in   N_REQ             requester accepts read data
//  o_m_wen, o_m_wdata_valid  out 1    memory write strobe/valid (driven identically)
//  o_m_waddr   out  ADDR_WIDTH        memory write address
//  o_m_wdata   out  DATA_WIDTH        memory write data
//  i_m_wdata_ready   in 1             memory accepts write
//  o_m_raddr_valid   out 1            memory read-address valid
//  o_m_raddr   out  ADDR_WIDTH        memory read address
//  i_m_raddr_ready   in 1             memory accepts read address
//  i_m_rdata_valid   in 1             memory read data valid
//  i_m_rdata   in   DATA_WIDTH        memory read data
//  o_m_rdata_ready   out 1            = i_r_ready[owner]
//  o_rsp_err   out  1                 sticky: response arrived with no outstanding owner
// BEHAVIOUR
//  Reset (i_rstn=0 at edge): both RR pointers=0, locks clear, FIFO empty, o_rsp_err=0.
//   All m_* valids, o_w_ready, o_ra_ready and o_r_valid are 0 while reset is held.
//   Reset mid-transaction drops in-flight ownership. Late memory responses then set o_rsp_err.
//  Write channel, states IDLE/LOCKED:
//   IDLE: grant = first i_w_valid at or after w_ptr (wrapping). Grant is combinational, zero-cycle.
//   The granted request drives o_m_*; o_m_wen = o_m_wdata_valid = |i_w_valid.
//   o_w_ready[g] = i_m_wdata_ready & granted. Handshake: w_ptr <= (g+1) mod N_REQ, stay IDLE.
//   No handshake: register g, go LOCKED. LOCKED holds g regardless of other requesters.
//   LOCKED returns to IDLE on handshake. Requesters must hold valid/addr/data stable until ready.
//  Read-address channel: same IDLE/LOCKED scheme with its own ra_ptr.
//   o_m_raddr_valid is gated by !fifo_full.
//   Handshake (o_m_raddr_valid & i_m_raddr_ready) pushes g into the owner FIFO.
//   FIFO full: o_m_raddr_valid=0 and no ra_ready. A grant already LOCKED stays locked.
//  Response routing: owner = FIFO head.
//   o_r_valid[owner] = i_m_rdata_valid & !empty; o_m_rdata_ready = i_r_ready[owner] & !empty.
//   Handshake pops the head. Push and pop in the same cycle keep the count unchanged.
//   i_m_rdata_valid while empty sets o_rsp_err; the beat is not routed.
//  No same-cycle bypass: a pushed ID is visible at the head next cycle. Memory latency must be >=1.
//  Write and read to the same address in one cycle are both forwarded; ordering belongs to memory.
//  Channels are independent: one write and one read can be granted per cycle.
//  Pointer arithmetic is modulo N_REQ; index width is $clog2(N_REQ).
//  FIFO count width is $clog2(MAX_OUTSTANDING)+1; rd/wr pointers wrap naturally.
// STRUCTURE
//  cg_memory_arbiter_pkg: arb_state_e {ARB_IDLE, ARB_LOCKED} and the idx-width localparam helper.
//  Sub-module cg_rr_arbiter #(N) (i_req, i_ptr -> o_gnt_onehot, o_gnt_idx, o_any):
//   combinational priority rotate, instantiated once per channel.
//  Lock registers, pointers and owner FIFO are inline.
// TESTING
//  1. Reset, then req0 writes 0x514<-0x114 with mem ready=1:
//     o_m_waddr=0x514 and o_w_ready=0001 in the same cycle, w_ptr=1 next cycle.
//  2. All 4 write requests held, mem ready=1 continuously -> grants 0,1,2,3,0, one per cycle.
//  3. req2 granted, i_m_wdata_ready=0 for 3 cycles while req1 rises:
//     grant stays 2 (LOCKED), then o_w_ready=0100, then req1 granted.
//  4. req1 reads 0x516, req3 reads 0x514 back-to-back, mem latency 2:
//     first beat -> o_r_valid=0010, second -> 1000.
//     Hold i_r_ready[1]=0 two cycles: o_m_rdata_ready=0 and no pop.
//  5. 5 reads issued with 4 unanswered -> 5th sees o_ra_ready=0 until the first response pops.
//     Pulse i_m_rdata_valid with FIFO empty -> o_rsp_err=1 until reset.
//  6. Same cycle: req0 write 0x516<-0x314 and req2 read 0x516 -> both memory channels valid together.
//     Assert reset mid-lock -> all outputs 0, pointers 0 next cycle.

Source files
------------

// File: rtl/cg_memory_arbiter_pkg.sv
// Shared types and helpers for the memory arbiter slice.
// Used by the top-level arbiter and the round-robin picker.
package cg_memory_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // An index into a set of n entries needs at least one bit, even when n is 1.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cg_rr_arbiter.sv
// Combinational round-robin picker.
// Grants the first request found at or after i_ptr, wrapping modulo N.
module cg_rr_arbiter
  import cg_memory_arbiter_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idxWidth(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt_onehot,
  output logic [IW-1:0] o_gnt_idx,
  output logic          o_any
);

  logic [IW-1:0] candIdx;

  // Walk from farthest to nearest, so the request closest to i_ptr wins.
  always_comb begin
    o_gnt_onehot = '0;
    o_gnt_idx    = '0;
    o_any        = 1'b0;
    candIdx      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      candIdx = IW'((int'(i_ptr) + k) % N);
      if (i_req[candIdx]) begin
        o_gnt_onehot          = '0;
        o_gnt_onehot[candIdx] = 1'b1;
        o_gnt_idx             = candIdx;
        o_any                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cg_memory_arbiter.sv
// Shares one memory port among N_REQ requesters.
// Writes and read addresses are arbitrated independently; read data is routed through an in-order owner FIFO.
module cg_memory_arbiter
  import cg_memory_arbiter_pkg::*;
#(
  parameter int N_REQ           = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic [N_REQ-1:0]            i_w_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] i_w_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_w_data,
  output logic [N_REQ-1:0]            o_w_ready,
  input  logic [N_REQ-1:0]            i_ra_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] i_ra_addr,
  output logic [N_REQ-1:0]            o_ra_ready,
  output logic [N_REQ-1:0]            o_r_valid,
  output logic [DATA_WIDTH-1:0]       o_r_data,
  input  logic [N_REQ-1:0]            i_r_ready,
  output logic                        o_m_wen,
  output logic                        o_m_wdata_valid,
  output logic [ADDR_WIDTH-1:0]       o_m_waddr,
  output logic [DATA_WIDTH-1:0]       o_m_wdata,
  input  logic                        i_m_wdata_ready,
  output logic                        o_m_raddr_valid,
  output logic [ADDR_WIDTH-1:0]       o_m_raddr,
  input  logic                        i_m_raddr_ready,
  input  logic                        i_m_rdata_valid,
  input  logic [DATA_WIDTH-1:0]       i_m_rdata,
  output logic                        o_m_rdata_ready,
  output logic                        o_rsp_err
);

  localparam int IW = idxWidth(N_REQ);
  localparam int PW = idxWidth(MAX_OUTSTANDING);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  function automatic logic [IW-1:0] nextIdx(input logic [IW-1:0] g);
    return (g == IW'(N_REQ - 1)) ? '0 : g + IW'(1);
  endfunction

  logic [ADDR_WIDTH-1:0] wAddrArr  [N_REQ];
  logic [DATA_WIDTH-1:0] wDataArr  [N_REQ];
  logic [ADDR_WIDTH-1:0] raAddrArr [N_REQ];

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      wAddrArr[k]  = i_w_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      wDataArr[k]  = i_w_data[k*DATA_WIDTH +: DATA_WIDTH];
      raAddrArr[k] = i_ra_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  arb_state_e    wState_q, wState_d, raState_q, raState_d;
  logic [IW-1:0] wLock_q, wLock_d, raLock_q, raLock_d;
  logic [IW-1:0] wPtr_q, wPtr_d, raPtr_q, raPtr_d;
  logic [N_REQ-1:0] wRrOnehot, raRrOnehot;
  logic [IW-1:0] wRrIdx, raRrIdx, wGnt, raGnt;
  logic          wRrAny, raRrAny, wValid, raValid, wHs, raHs;

  logic [IW-1:0] fifoMem_q [MAX_OUTSTANDING];
  logic [PW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rspErr_q, rspErr_d;
  logic          fifoFull, fifoEmpty, rspValid, push, pop;
  logic [IW-1:0] owner;

  cg_rr_arbiter #(.N(N_REQ)) uWriteArb (
    .i_req(i_w_valid), .i_ptr(wPtr_q),
    .o_gnt_onehot(wRrOnehot), .o_gnt_idx(wRrIdx), .o_any(wRrAny)
  );

  cg_rr_arbiter #(.N(N_REQ)) uReadArb (
    .i_req(i_ra_valid), .i_ptr(raPtr_q),
    .o_gnt_onehot(raRrOnehot), .o_gnt_idx(raRrIdx), .o_any(raRrAny)
  );

  assign fifoFull  = (count_q == CW'(MAX_OUTSTANDING));
  assign fifoEmpty = (count_q == '0);
  assign owner     = fifoMem_q[rdPtr_q];

  // A locked channel ignores the picker and keeps presenting the stalled requester.
  always_comb begin
    wGnt   = (wState_q == ARB_LOCKED) ? wLock_q : wRrIdx;
    wValid = i_rstn & ((wState_q == ARB_LOCKED) ? i_w_valid[wLock_q] : wRrAny);
    wHs    = wValid & i_m_wdata_ready;
    raGnt  = (raState_q == ARB_LOCKED) ? raLock_q : raRrIdx;
    raValid = i_rstn & !fifoFull &
              ((raState_q == ARB_LOCKED) ? i_ra_valid[raLock_q] : raRrAny);
    raHs   = raValid & i_m_raddr_ready;

    o_m_wen         = wValid;
    o_m_wdata_valid = wValid;
    o_m_waddr       = wAddrArr[wGnt];
    o_m_wdata       = wDataArr[wGnt];
    o_w_ready       = wHs ? (ONE << wGnt) : '0;
    o_m_raddr_valid = raValid;
    o_m_raddr       = raAddrArr[raGnt];
    o_ra_ready      = raHs ? (ONE << raGnt) : '0;

    rspValid        = i_rstn & i_m_rdata_valid & !fifoEmpty;
    o_r_valid       = rspValid ? (ONE << owner) : '0;
    o_r_data        = i_m_rdata;
    o_m_rdata_ready = i_rstn & !fifoEmpty & i_r_ready[owner];
    o_rsp_err       = rspErr_q;
    push            = raHs;
    pop             = rspValid & i_r_ready[owner];
  end

  always_comb begin
    wState_d  = wState_q;
    wLock_d   = wLock_q;
    wPtr_d    = wPtr_q;
    raState_d = raState_q;
    raLock_d  = raLock_q;
    raPtr_d   = raPtr_q;
    if (wHs) begin
      wState_d = ARB_IDLE;
      wPtr_d   = nextIdx(wGnt);
    end else if (wValid && wState_q == ARB_IDLE) begin
      wState_d = ARB_LOCKED;
      wLock_d  = wGnt;
    end
    if (raHs) begin
      raState_d = ARB_IDLE;
      raPtr_d   = nextIdx(raGnt);
    end else if (raValid && raState_q == ARB_IDLE) begin
      raState_d = ARB_LOCKED;
      raLock_d  = raGnt;
    end

    wrPtr_d  = push ? wrPtr_q + PW'(1) : wrPtr_q;
    rdPtr_d  = pop  ? rdPtr_q + PW'(1) : rdPtr_q;
    count_d  = count_q;
    if (push && !pop)
      count_d = count_q + CW'(1);
    else if (pop && !push)
      count_d = count_q - CW'(1);
    rspErr_d = rspErr_q | (i_m_rdata_valid & fifoEmpty);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wState_q  <= ARB_IDLE;
      wLock_q   <= '0;
      wPtr_q    <= '0;
      raState_q <= ARB_IDLE;
      raLock_q  <= '0;
      raPtr_q   <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      rspErr_q  <= 1'b0;
    end else begin
      wState_q  <= wState_d;
      wLock_q   <= wLock_d;
      wPtr_q    <= wPtr_d;
      raState_q <= raState_d;
      raLock_q  <= raLock_d;
      raPtr_q   <= raPtr_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      rspErr_q  <= rspErr_d;
    end
  end

  // Storage only; validity is tracked by count_q, so no reset is needed here.
  always_ff @(posedge i_clk) begin
    if (push)
      fifoMem_q[wrPtr_q] <= raGnt;
  end

endmodule

// File: tb/tb_cg_memory_arbiter.sv
// Directed bench for cg_memory_arbiter: write/read grants, locking, owner routing, FIFO full and error flag.
module tb_cg_memory_arbiter;

  logic         clk = 1'b0;
  logic         rstn;
  logic [3:0]   wValid, wReady, raValid, raReady, rValid, rReady;
  logic [127:0] wAddr, wData, raAddr;
  logic [31:0]  rData, mWaddr, mWdata, mRaddr, mRdata;
  logic         mWen, mWdataValid, mWdataReady, mRaddrValid, mRaddrReady;
  logic         mRdataValid, mRdataReady, rspErr;

  int checks = 0;
  int errors = 0;
  logic [3:0] expOwnerQ[$];

  always #5 clk = ~clk;

  cg_memory_arbiter dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_w_valid(wValid), .i_w_addr(wAddr), .i_w_data(wData), .o_w_ready(wReady),
    .i_ra_valid(raValid), .i_ra_addr(raAddr), .o_ra_ready(raReady),
    .o_r_valid(rValid), .o_r_data(rData), .i_r_ready(rReady),
    .o_m_wen(mWen), .o_m_wdata_valid(mWdataValid), .o_m_waddr(mWaddr),
    .o_m_wdata(mWdata), .i_m_wdata_ready(mWdataReady),
    .o_m_raddr_valid(mRaddrValid), .o_m_raddr(mRaddr), .i_m_raddr_ready(mRaddrReady),
    .i_m_rdata_valid(mRdataValid), .i_m_rdata(mRdata), .o_m_rdata_ready(mRdataReady),
    .o_rsp_err(rspErr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] wv, input logic wr,
                               input logic [3:0] rav, input logic rar);
    wValid      = wv;
    mWdataReady = wr;
    raValid     = rav;
    mRaddrReady = rar;
    #1;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkRsp(input string tag);
    logic [3:0] exp;
    if (expOwnerQ.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s: observed response expected none queued", tag);
    end else begin
      exp = expOwnerQ.pop_front();
      checkOutput(tag, 32'(rValid), 32'(exp));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    wAddr = '0; wData = '0; raAddr = '0;
    rReady = 4'b1111; mRdataValid = 1'b0; mRdata = '0;
    applyStimulus(4'b1111, 1'b1, 4'b1111, 1'b1);
    checkOutput("rst_w_ready", 32'(wReady), 0);
    checkOutput("rst_m_wen", 32'(mWen), 0);
    checkOutput("rst_ra_valid", 32'(mRaddrValid), 0);
    stepCycle();
    stepCycle();
    rstn = 1'b1;
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
    stepCycle();
    checkOutput("rst_err", 32'(rspErr), 0);
    checkOutput("rst_r_valid", 32'(rValid), 0);

    // Single write from req0, then w_ptr should favour req1 over req0
    wAddr[0 +: 32] = 32'h514; wData[0 +: 32] = 32'h114;
    wAddr[32 +: 32] = 32'h600;
    applyStimulus(4'b0001, 1'b1, 4'b0000, 1'b0);
    checkOutput("t1_waddr", mWaddr, 32'h514);
    checkOutput("t1_wdata", mWdata, 32'h114);
    checkOutput("t1_w_ready", 32'(wReady), 32'h1);
    checkOutput("t1_wdata_valid", 32'(mWdataValid), 1);
    stepCycle();
    applyStimulus(4'b0011, 1'b1, 4'b0000, 1'b0);
    checkOutput("t1_ptr_next", 32'(wReady), 32'h2);
    checkOutput("t1_ptr_addr", mWaddr, 32'h600);

    // All four held with memory always ready: rotation from a fresh pointer
    rstn = 1'b0;
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
    stepCycle();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wAddr[i*32 +: 32] = 32'h100 + 32'(i);
      wData[i*32 +: 32] = 32'h200 + 32'(i);
    end
    expOwnerQ.push_back(4'b0001);
    expOwnerQ.push_back(4'b0010);
    expOwnerQ.push_back(4'b0100);
    expOwnerQ.push_back(4'b1000);
    expOwnerQ.push_back(4'b0001);
    applyStimulus(4'b1111, 1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      logic [3:0] exp;
      exp = expOwnerQ.pop_front();
      checkOutput($sformatf("t2_grant%0d", i), 32'(wReady), 32'(exp));
      checkOutput($sformatf("t2_addr%0d", i), mWaddr, 32'h100 + 32'(i % 4));
      stepCycle();
    end

    // req2 stalls; req1 rising must not steal the locked grant
    applyStimulus(4'b0100, 1'b0, 4'b0000, 1'b0);
    checkOutput("t3_first_addr", mWaddr, 32'h102);
    checkOutput("t3_first_ready", 32'(wReady), 0);
    stepCycle();
    applyStimulus(4'b0110, 1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("t3_lock_addr%0d", i), mWaddr, 32'h102);
      checkOutput($sformatf("t3_lock_wen%0d", i), 32'(mWen), 1);
      stepCycle();
    end
    applyStimulus(4'b0110, 1'b1, 4'b0000, 1'b0);
    checkOutput("t3_release", 32'(wReady), 32'h4);
    stepCycle();
    applyStimulus(4'b0010, 1'b1, 4'b0000, 1'b0);
    checkOutput("t3_req1", 32'(wReady), 32'h2);
    checkOutput("t3_req1_addr", mWaddr, 32'h101);
    stepCycle();

    // Two reads back-to-back, responses two cycles later routed in issue order
    raAddr[32 +: 32] = 32'h516;
    raAddr[96 +: 32] = 32'h514;
    applyStimulus(4'b0000, 1'b0, 4'b0010, 1'b1);
    checkOutput("t4_raddr1", mRaddr, 32'h516);
    checkOutput("t4_ra_ready1", 32'(raReady), 32'h2);
    if (raReady == 4'b0010) expOwnerQ.push_back(4'b0010);
    stepCycle();
    applyStimulus(4'b0000, 1'b0, 4'b1000, 1'b1);
    checkOutput("t4_raddr3", mRaddr, 32'h514);
    checkOutput("t4_ra_ready3", 32'(raReady), 32'h8);
    if (raReady == 4'b1000) expOwnerQ.push_back(4'b1000);
    stepCycle();
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
    mRdataValid = 1'b1; mRdata = 32'hA1; rReady = 4'b1101;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("t4_hold_valid%0d", i), 32'(rValid), 32'h2);
      checkOutput($sformatf("t4_hold_ready%0d", i), 32'(mRdataReady), 0);
      stepCycle();
    end
    rReady = 4'b1111;
    #1;
    checkRsp("t4_beat1");
    checkOutput("t4_beat1_data", rData, 32'hA1);
    checkOutput("t4_beat1_ready", 32'(mRdataReady), 1);
    stepCycle();
    mRdata = 32'hB3;
    #1;
    checkRsp("t4_beat2");
    stepCycle();
    mRdataValid = 1'b0;
    #1;
    checkOutput("t4_idle", 32'(rValid), 0);

    // Fill the owner FIFO, then a fifth read must wait for a pop
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0000, 1'b0, 4'(1 << i), 1'b1);
      checkOutput($sformatf("t5_fill%0d", i), 32'(raReady), 32'(1 << i));
      expOwnerQ.push_back(4'(1 << i));
      stepCycle();
    end
    applyStimulus(4'b0000, 1'b0, 4'b0001, 1'b1);
    checkOutput("t5_full_valid", 32'(mRaddrValid), 0);
    checkOutput("t5_full_ready", 32'(raReady), 0);
    stepCycle();
    mRdataValid = 1'b1; mRdata = 32'hC0;
    #1;
    checkOutput("t5_full_pop_cycle", 32'(raReady), 0);
    checkRsp("t5_rsp0");
    stepCycle();
    mRdataValid = 1'b0;
    #1;
    checkOutput("t5_fifth_ready", 32'(raReady), 32'h1);
    expOwnerQ.push_back(4'b0001);
    stepCycle();
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
    mRdataValid = 1'b1;
    for (int i = 1; i < 5; i++) begin
      #0;
      checkRsp($sformatf("t5_rsp%0d", i));
      stepCycle();
    end
    checkOutput("t5_empty_route", 32'(rValid), 0);
    checkOutput("t5_empty_rdy", 32'(mRdataReady), 0);
    stepCycle();
    mRdataValid = 1'b0;
    #1;
    checkOutput("t5_err_set", 32'(rspErr), 1);
    stepCycle();
    checkOutput("t5_err_sticky", 32'(rspErr), 1);

    // Concurrent write and read to the same address
    wAddr[0 +: 32] = 32'h516; wData[0 +: 32] = 32'h314;
    raAddr[64 +: 32] = 32'h516;
    applyStimulus(4'b0001, 1'b1, 4'b0100, 1'b1);
    checkOutput("t6_wen", 32'(mWen), 1);
    checkOutput("t6_raddr_valid", 32'(mRaddrValid), 1);
    checkOutput("t6_waddr", mWaddr, 32'h516);
    checkOutput("t6_wdata", mWdata, 32'h314);
    checkOutput("t6_raddr", mRaddr, 32'h516);
    checkOutput("t6_w_ready", 32'(wReady), 32'h1);
    checkOutput("t6_ra_ready", 32'(raReady), 32'h4);
    stepCycle();
    applyStimulus(4'b0010, 1'b0, 4'b0100, 1'b0);
    stepCycle();
    rstn = 1'b0;
    mRdataValid = 1'b1;
    #1;
    checkOutput("t6_rst_w_ready", 32'(wReady), 0);
    checkOutput("t6_rst_wen", 32'(mWen), 0);
    checkOutput("t6_rst_raddr_valid", 32'(mRaddrValid), 0);
    checkOutput("t6_rst_r_valid", 32'(rValid), 0);
    stepCycle();
    expOwnerQ.delete();
    checkOutput("t6_rst_err", 32'(rspErr), 0);
    rstn = 1'b1;
    mRdataValid = 1'b0;
    applyStimulus(4'b1111, 1'b1, 4'b1111, 1'b1);
    checkOutput("t6_wptr0", 32'(wReady), 32'h1);
    checkOutput("t6_raptr0", 32'(raReady), 32'h1);
    applyStimulus(4'b0000, 1'b0, 4'b0000, 1'b0);
    mRdataValid = 1'b1;
    #1;
    checkOutput("t6_late_unrouted", 32'(rValid), 0);
    stepCycle();
    mRdataValid = 1'b0;
    #1;
    checkOutput("t6_late_err", 32'(rspErr), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
